// File: rtl/dmem_lsu.sv
//------------------------------------------------------------------------------
// Module  : dmem_lsu
// Brief   : Load/store unit bridging the core mem stage to a req/gnt data
//           memory with byte enables, lane steering and load extension.
//           Optional response timeout: define DMEM_LSU_TIMEOUT_EN.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_lsu #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_valid,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [1:0]        core_size,
  input  logic              core_unsigned,
  output logic              core_stall,
  output logic              core_done,
  output logic              core_err,
  output logic [DATA_W-1:0] core_rdata,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t              r_state;
  logic [2:0]          r_off;
  logic [1:0]          r_size;
  logic                r_unsigned;

  logic [2:0]          w_off;
  logic                w_aligned;
  logic [7:0]          w_be_base;
  logic [DATA_W-1:0]   w_mask;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_rshift;
  logic [DATA_W-1:0]   w_ext;
  logic                w_sign;
  logic                w_timeout;

  assign w_off = core_addr[2:0];

  always_comb begin
    w_aligned = 1'b1;
    w_be_base = 8'h01;
    w_mask    = 64'h0000_0000_0000_00FF;
    case (core_size)
      2'd1: begin
        w_aligned = (core_addr[0] == 1'b0);
        w_be_base = 8'h03;
        w_mask    = 64'h0000_0000_0000_FFFF;
      end
      2'd2: begin
        w_aligned = (core_addr[1:0] == 2'b00);
        w_be_base = 8'h0F;
        w_mask    = 64'h0000_0000_FFFF_FFFF;
      end
      2'd3: begin
        w_aligned = (core_addr[2:0] == 3'b000);
        w_be_base = 8'hFF;
        w_mask    = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      default: ;
    endcase
  end

  // Masking first keeps lanes above the access at zero after the shift.
  assign w_wdata  = (core_wdata & w_mask) << {w_off, 3'b000};
  assign w_rshift = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_sign = 1'b0;
    w_ext  = w_rshift;
    case (r_size)
      2'd0: begin
        w_sign = ~r_unsigned & w_rshift[7];
        w_ext  = {{56{w_sign}}, w_rshift[7:0]};
      end
      2'd1: begin
        w_sign = ~r_unsigned & w_rshift[15];
        w_ext  = {{48{w_sign}}, w_rshift[15:0]};
      end
      2'd2: begin
        w_sign = ~r_unsigned & w_rshift[31];
        w_ext  = {{32{w_sign}}, w_rshift[31:0]};
      end
      default: w_ext = w_rshift;
    endcase
  end

`ifdef DMEM_LSU_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_lim = c_cnt_w'(TIMEOUT_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_cnt;

  // Held at zero in IDLE so it starts from zero on every entry to REQ.
  always_ff @(posedge clk) begin
    if (rst || r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if (r_state == S_REQ || r_state == S_WAIT) begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  assign w_timeout = (r_state == S_REQ || r_state == S_WAIT) && (r_cnt == c_cnt_lim);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC != 0);
  assign w_timeout        = 1'b0;
`endif

  assign core_stall = core_req_valid && !(r_state == S_DONE || r_state == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_off      <= 3'd0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      core_done  <= 1'b0;
      core_err   <= 1'b0;
      core_rdata <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 8'h00;
      mem_wdata  <= '0;
    end else begin
      core_done  <= 1'b0;
      core_err   <= 1'b0;
      core_rdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (core_req_valid) begin
            if (w_aligned) begin
              r_state    <= S_REQ;
              r_off      <= w_off;
              r_size     <= core_size;
              r_unsigned <= core_unsigned;
              mem_req    <= 1'b1;
              mem_we     <= core_we;
              mem_addr   <= {core_addr[ADDR_W-1:3], 3'b000};
              mem_be     <= w_be_base << w_off;
              mem_wdata  <= w_wdata;
            end else begin
              r_state   <= S_ERR;
              core_done <= 1'b1;
              core_err  <= 1'b1;
            end
          end
        end
        S_REQ, S_WAIT: begin
          if (w_timeout) begin
            r_state   <= S_ERR;
            mem_req   <= 1'b0;
            core_done <= 1'b1;
            core_err  <= 1'b1;
          end else if (r_state == S_REQ) begin
            if (mem_gnt) begin
              r_state <= S_WAIT;
              mem_req <= 1'b0;
            end
          end else if (mem_rvalid) begin
            r_state    <= S_DONE;
            core_done  <= 1'b1;
            core_rdata <= mem_we ? '0 : w_ext;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu.sv
//------------------------------------------------------------------------------
// Module  : tb_dmem_lsu
// Brief   : Self-checking bench for dmem_lsu: directed vector table, corner
//           sequences and randomized accesses against a reference model.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_valid, core_we, core_unsigned;
  logic [63:0] core_addr, core_wdata;
  logic [1:0]  core_size;
  logic        core_stall, core_done, core_err;
  logic [63:0] core_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_be;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_size(core_size), .core_unsigned(core_unsigned),
    .core_stall(core_stall), .core_done(core_done), .core_err(core_err),
    .core_rdata(core_rdata),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] mrdata;
    int          gnt_d;
    int          rv_d;
    logic        err;
    logic [7:0]  be;
    logic [63:0] maddr;
    logic [63:0] mwdata;
    logic [63:0] rdata;
    int          cyc;
  } vec_t;

  typedef struct {
    logic        done;
    int          cyc;
    logic        err;
    logic [63:0] rdata;
    logic        saw_req;
    logic [7:0]  be;
    logic [63:0] maddr;
    logic [63:0] mwdata;
    logic        mwe;
    logic        stall_bad;
    logic        stable_bad;
  } res_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one access and acts as the memory: grants gnt_d cycles after
  // mem_req rises, responds rv_d cycles after the grant.
  task automatic run_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [1:0] size, input logic uns, input logic [63:0] mrdata,
                         input int gnt_d, input int rv_d, input int budget, output res_t res);
    int  cyc = 0;
    int  wait_g = 0;
    int  since_g = 0;
    bit  granted = 0;
    res = '{default: '0};
    core_req_valid = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
    core_size = size; core_unsigned = uns;
    while (1) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = ~mrdata;
      if (!granted && mem_req) begin
        if (!res.saw_req) begin
          res.saw_req = 1'b1; res.be = mem_be; res.maddr = mem_addr;
          res.mwdata = mem_wdata; res.mwe = mem_we;
        end else if (mem_be !== res.be || mem_addr !== res.maddr ||
                     mem_wdata !== res.mwdata || mem_we !== res.mwe) begin
          res.stable_bad = 1'b1;
        end
        if (wait_g == gnt_d) begin mem_gnt = 1'b1; granted = 1; end
        else wait_g++;
      end else if (granted) begin
        if (mem_req) res.stable_bad = 1'b1;
        since_g++;
        if (since_g == rv_d) begin mem_rvalid = 1'b1; mem_rdata = mrdata; end
      end
      @(negedge clk);
      if (core_done) begin
        res.done = 1'b1; res.cyc = cyc; res.err = core_err; res.rdata = core_rdata;
        if (core_stall) res.stall_bad = 1'b1;
        break;
      end
      if (!core_stall) res.stall_bad = 1'b1;
      if (cyc >= budget) break;
      step();
      cyc++;
    end
    step();
    core_req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  // Reference: derived directly from the sizing and extension rules.
  task automatic ref_model(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [1:0] size, input logic uns, input logic [63:0] mrdata,
                           output logic err, output logic [7:0] be, output logic [63:0] maddr,
                           output logic [63:0] mwdata, output logic [63:0] rdata);
    int          nbytes = 1 << size;
    int          off = int'(addr[2:0]);
    logic [63:0] mask;
    logic [63:0] val;
    err    = (addr % nbytes) != 0;
    be     = 8'(((1 << nbytes) - 1) << off);
    maddr  = addr & ~64'd7;
    mask   = (nbytes == 8) ? ~64'd0 : ((64'd1 << (8 * nbytes)) - 64'd1);
    mwdata = (wdata & mask) << (8 * off);
    val    = (mrdata >> (8 * off)) & mask;
    if (!uns && nbytes < 8 && val[8 * nbytes - 1]) val = val | ~mask;
    rdata  = we ? 64'd0 : val;
  endtask

  vec_t vecs[9];

  initial begin
    res_t        r;
    logic        e_err;
    logic [7:0]  e_be;
    logic [63:0] e_addr, e_wdata, e_rdata;
    bit          bad;

    vecs[0] = '{1'b0, 64'h1004, 64'h0, 2'd2, 1'b0, 64'h80000001_00000000, 0, 1,
                1'b0, 8'hF0, 64'h1000, 64'h0, 64'hFFFFFFFF_80000001, 3};
    vecs[1] = '{1'b0, 64'h2007, 64'h0, 2'd0, 1'b1, 64'hAB000000_00000000, 0, 1,
                1'b0, 8'h80, 64'h2000, 64'h0, 64'h00000000_000000AB, 3};
    vecs[2] = '{1'b1, 64'h3002, 64'h1234, 2'd1, 1'b0, 64'h0, 0, 1,
                1'b0, 8'h0C, 64'h3000, 64'h00000000_12340000, 64'h0, 3};
    vecs[3] = '{1'b0, 64'h4002, 64'h0, 2'd2, 1'b0, 64'h0, 0, 1,
                1'b1, 8'h00, 64'h0, 64'h0, 64'h0, 1};
    vecs[4] = '{1'b0, 64'h5000, 64'h0, 2'd3, 1'b0, 64'h01234567_89ABCDEF, 5, 1,
                1'b0, 8'hFF, 64'h5000, 64'h0, 64'h01234567_89ABCDEF, 8};
    vecs[5] = '{1'b0, 64'h6003, 64'h0, 2'd0, 1'b0, 64'h00000000_80000000, 0, 3,
                1'b0, 8'h08, 64'h6000, 64'h0, 64'hFFFFFFFF_FFFFFF80, 5};
    vecs[6] = '{1'b1, 64'h7001, 64'h55, 2'd1, 1'b0, 64'h0, 0, 1,
                1'b1, 8'h00, 64'h0, 64'h0, 64'h0, 1};
    vecs[7] = '{1'b1, 64'h8000, 64'hDEADBEEF_CAFEF00D, 2'd3, 1'b0, 64'h0, 2, 2,
                1'b0, 8'hFF, 64'h8000, 64'hDEADBEEF_CAFEF00D, 64'h0, 6};
    vecs[8] = '{1'b1, 64'h9005, 64'hFFFFFFFF_FFFFFF5A, 2'd0, 1'b0, 64'h0, 1, 1,
                1'b0, 8'h20, 64'h9000, 64'h00005A00_00000000, 64'h0, 4};

    rst = 1'b1; core_req_valid = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    core_size = 2'd0; core_unsigned = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) step();
    @(negedge clk);
    check("reset_outputs",
          {61'd0, core_done, core_err, mem_req} | core_rdata | mem_addr | mem_wdata |
          {55'd0, mem_we, mem_be} | {63'd0, core_stall}, 64'd0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns,
              vecs[i].mrdata, vecs[i].gnt_d, vecs[i].rv_d, 100, r);
      check($sformatf("vec%0d_done", i), {63'd0, r.done}, 64'd1);
      check($sformatf("vec%0d_err", i), {63'd0, r.err}, {63'd0, vecs[i].err});
      check($sformatf("vec%0d_cycle", i), 64'(r.cyc), 64'(vecs[i].cyc));
      check($sformatf("vec%0d_rdata", i), r.rdata, vecs[i].rdata);
      check($sformatf("vec%0d_stall", i), {63'd0, r.stall_bad}, 64'd0);
      if (vecs[i].err) begin
        check($sformatf("vec%0d_no_req", i), {63'd0, r.saw_req}, 64'd0);
      end else begin
        check($sformatf("vec%0d_be", i), {56'd0, r.be}, {56'd0, vecs[i].be});
        check($sformatf("vec%0d_addr", i), r.maddr, vecs[i].maddr);
        check($sformatf("vec%0d_we", i), {63'd0, r.mwe}, {63'd0, vecs[i].we});
        check($sformatf("vec%0d_stable", i), {63'd0, r.stable_bad}, 64'd0);
        if (vecs[i].we) check($sformatf("vec%0d_wdata", i), r.mwdata, vecs[i].mwdata);
      end
      step();
    end

    // mem_rvalid while still in REQ must not complete the access.
    core_req_valid = 1'b1; core_we = 1'b0; core_addr = 64'hA000; core_size = 2'd3;
    core_unsigned = 1'b0;
    step();
    mem_rvalid = 1'b1; mem_rdata = 64'h1111;
    step();
    @(negedge clk);
    check("rvalid_in_req_ignored", {62'd0, mem_req, core_done}, 64'd2);
    step();
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hCAFE_0000_0000_BEEF;
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("req_rvalid_done", {63'd0, core_done}, 64'd1);
    check("req_rvalid_data", core_rdata, 64'hCAFE_0000_0000_BEEF);
    step();
    core_req_valid = 1'b0;
    step();

    // Reset while waiting for the response; a late rvalid is then ignored.
    core_req_valid = 1'b1; core_we = 1'b0; core_addr = 64'hB000; core_size = 2'd2;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; core_req_valid = 1'b0;
    @(negedge clk);
    check("reset_wait_mem_req", {62'd0, mem_req, core_done}, 64'd0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 64'h5;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (core_done || mem_req) bad = 1;
      step();
      mem_rvalid = 1'b0;
    end
    check("late_rvalid_ignored", {63'd0, bad}, 64'd0);

`ifdef DMEM_LSU_TIMEOUT_EN
    run_txn(1'b0, 64'hC000, 64'h0, 2'd3, 1'b0, 64'h0, 1000, 1, 100, r);
    check("timeout_done", {63'd0, r.done}, 64'd1);
    check("timeout_err", {63'd0, r.err}, 64'd1);
    check("timeout_cycle", 64'(r.cyc), 64'd5);
    @(negedge clk);
    check("timeout_mem_req", {63'd0, mem_req}, 64'd0);
    step();
`else
    core_req_valid = 1'b1; core_we = 1'b0; core_addr = 64'hC000; core_size = 2'd3;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (core_done) bad = 1;
      step();
    end
    @(negedge clk);
    check("pending_no_done", {63'd0, bad}, 64'd0);
    check("pending_at_50", {62'd0, mem_req, core_stall}, 64'd3);
    step();
    rst = 1'b1; core_req_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
`endif

    for (int t = 0; t < 150; t++) begin
      logic        we, uns;
      logic [63:0] addr, wdata, mrd;
      logic [1:0]  size;
      int          gd, rd;
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      addr  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << size) - 64'd1);
      wdata = {$urandom, $urandom};
      mrd   = {$urandom, $urandom};
      gd    = $urandom_range(0, 3);
      rd    = $urandom_range(1, 3);
      ref_model(we, addr, wdata, size, uns, mrd, e_err, e_be, e_addr, e_wdata, e_rdata);
      run_txn(we, addr, wdata, size, uns, mrd, gd, rd, 100, r);
      check("rand_done", {63'd0, r.done}, 64'd1);
      check("rand_err", {63'd0, r.err}, {63'd0, e_err});
      check("rand_rdata", r.rdata, e_err ? 64'd0 : e_rdata);
      check("rand_cycle", 64'(r.cyc), e_err ? 64'd1 : 64'(2 + gd + rd));
      check("rand_stall", {63'd0, r.stall_bad}, 64'd0);
      if (!e_err) begin
        check("rand_be", {56'd0, r.be}, {56'd0, e_be});
        check("rand_addr", r.maddr, e_addr);
        check("rand_we", {63'd0, r.mwe}, {63'd0, we});
        check("rand_stable", {63'd0, r.stable_bad}, 64'd0);
        if (we) check("rand_wdata", r.mwdata, e_wdata);
      end else begin
        check("rand_no_req", {63'd0, r.saw_req}, 64'd0);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit between the core's execute/mem stage and a handshaked data memory.
- Core side: one access at a time, held until done.
- Memory side: 64-bit word-aligned bus with byte enables, req/gnt handshake and a variable-latency response.
- Handles byte/half/word/double sizing, lane steering, sign/zero extension, misalignment detection and core stall generation.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width (fixed 64; byte lanes = 8)
- TIMEOUT_CYC, 255, response-wait limit; used only with the optional feature

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- core_req_valid  in  1  access requested; held stable until core_done
- core_we  in  1  1 = store, 0 = load
- core_addr  in  ADDR_W  byte address
- core_wdata  in  64  store data, right-aligned
- core_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- core_unsigned  in  1  load zero-extends when 1
- core_stall  out  1  core_req_valid && !core_done
- core_done  out  1  one-cycle completion pulse
- core_err  out  1  valid with core_done; misaligned access (or timeout)
- core_rdata  out  64  extended load data, valid with core_done
- mem_req  out  1  memory request
- mem_gnt  in  1  request accepted this cycle
- mem_we  out  1  write
- mem_addr  out  ADDR_W  core_addr with bits [2:0] forced to 0
- mem_be  out  8  byte enables
- mem_wdata  out  64  lane-steered store data
- mem_rvalid  in  1  response (read data or write ack)
- mem_rdata  in  64  read word

Behaviour:
- Reset: all outputs 0, FSM to IDLE. Reset mid-access abandons the access: mem_req drops the next edge. A late mem_rvalid is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE, ERR.
- IDLE:
  - core_req_valid && aligned → REQ. Registers mem_addr, mem_we, mem_be and mem_wdata, plus offset/size/unsigned.
  - core_req_valid && misaligned → ERR.
  - Aligned means core_addr mod (1 << core_size) == 0.
- REQ: mem_req = 1 with all mem_* stable until mem_gnt. mem_gnt → WAIT, mem_req = 0 the next cycle.
- WAIT:
  - mem_rvalid → DONE. For loads, capture mem_rdata >> (8 × off), where off = addr[2:0].
  - Truncate to the access size, then sign- or zero-extend.
  - mem_rvalid is never asserted in the same cycle as its mem_gnt; if seen in REQ, it is ignored.
- DONE: core_done = 1, core_err = 0, core_rdata valid (0 for stores) → IDLE.
- ERR: core_done = 1, core_err = 1, core_rdata = 0, no memory access → IDLE.
- Next access: the core drops or changes its request in the cycle after core_done. IDLE samples core_req_valid again the cycle after DONE/ERR, so there is no back-to-back duplicate.
- mem_be: ((1 << (1 << size)) − 1) << off.
- mem_wdata: core_wdata << (8 × off); unused lanes are don't-care but driven 0.
- Minimum latency with gnt in the first REQ cycle and rvalid one cycle later: request in cycle 0 → mem_req in cycle 1 → rvalid in cycle 2 → core_done in cycle 3.
- core_stall is combinational from core_req_valid and the state.

Optional Feature:
- Macro: DMEM_LSU_TIMEOUT_EN.
- When defined:
  - An 8-bit counter (width sized to TIMEOUT_CYC) clears on entry to REQ and counts every REQ/WAIT cycle.
  - Reaching TIMEOUT_CYC → ERR: core_done = 1, core_err = 1, mem_req forced 0.
  - A later stray mem_rvalid is ignored.
- When undefined: no counter; REQ/WAIT wait indefinitely.

Test Plan:
- Load word, signed: addr 0x1004, size 2, mem_rdata 0x80000001_00000000 → mem_be 0xF0, mem_addr 0x1000, core_rdata 0xFFFFFFFF_80000001, done in cycle 3.
- Load byte, unsigned: addr 0x2007, core_unsigned = 1, mem_rdata 0xAB00…00 → mem_be 0x80, core_rdata 0x00000000_000000AB.
- Store half: addr 0x3002, wdata 0x1234 → mem_be 0x0C, mem_wdata[31:16] = 0x1234, mem_we = 1; core_done after rvalid with core_err = 0.
- Misaligned: word at 0x4002 → no mem_req, core_done = core_err = 1 in cycle 1; core_stall high only in cycle 0.
- Backpressure: mem_gnt held low 5 cycles → mem_req and mem_* stable throughout, core_stall high until done. Reset asserted in WAIT → next cycle state IDLE, mem_req = 0, later rvalid ignored.
- With DMEM_LSU_TIMEOUT_EN, TIMEOUT_CYC = 4, no gnt → core_err = 1 after 4 stall cycles. Without the macro, the request is still pending at cycle 50.
